// File: rtl/multi_user_free_queue_pkg.sv
// Shared definitions for the free-pointer queue of the shared-buffer switch core.
// Holds the default geometry, the FSM state type and the cell address mapping
// used by the 2k x 128 data SRAM ({ptr, word}).
package multi_user_free_queue_pkg;

  localparam int FQ_DEPTH    = 512;
  localparam int FQ_PTR_W    = 10;
  localparam int FQ_CNT_W    = 10;
  localparam int CELL_WORDS  = 4;
  localparam int CELL_WORD_W = $clog2(CELL_WORDS);

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } fq_state_e;

  // Data SRAM word address of word 'word' within cell 'ptr'.
  function automatic logic [FQ_PTR_W+CELL_WORD_W-1:0] cell_addr(
    input logic [FQ_PTR_W-1:0]    ptr,
    input logic [CELL_WORD_W-1:0] word
  );
    return {ptr, word};
  endfunction

endpackage

// File: rtl/multi_user_free_queue_if.sv
// Handshake bundle between the free-pointer queue and its users.
//   ptr_din/FQ_wr  : pointer return (push) from the read side
//   FQ_rd          : pointer pop request from the write side
//   ptr_dout_s     : show-ahead head pointer
//   ptr_fifo_empty : queue holds no pointers
//   FQ_act         : initialisation complete
//   FQ_count       : number of free pointers held
// master = queue user, slave = queue.
interface multi_user_free_queue_if #(
  parameter int PTR_W = 10,
  parameter int CNT_W = 10
);
  logic [15:0]      ptr_din;
  logic             FQ_wr;
  logic             FQ_rd;
  logic [PTR_W-1:0] ptr_dout_s;
  logic             ptr_fifo_empty;
  logic             FQ_act;
  logic [CNT_W-1:0] FQ_count;

  modport master (
    output ptr_din, FQ_wr, FQ_rd,
    input  ptr_dout_s, ptr_fifo_empty, FQ_act, FQ_count
  );

  modport slave (
    input  ptr_din, FQ_wr, FQ_rd,
    output ptr_dout_s, ptr_fifo_empty, FQ_act, FQ_count
  );
endinterface

// File: rtl/multi_user_free_queue_fq_ptr_ram.sv
// Pointer storage: DEPTH x PTR_W distributed RAM.
//   clk          : write clock
//   we/waddr/wdata : synchronous write port
//   raddr/rdata  : asynchronous read port
// Contents are not reset.
module fq_ptr_ram #(
  parameter int DEPTH = 512,
  parameter int PTR_W = 10,
  parameter int IDX_W = 9
) (
  input  logic             clk,
  input  logic             we,
  input  logic [IDX_W-1:0] waddr,
  input  logic [PTR_W-1:0] wdata,
  input  logic [IDX_W-1:0] raddr,
  output logic [PTR_W-1:0] rdata
);

  logic [PTR_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/multi_user_free_queue.sv
// Free-pointer queue: circular FIFO of free cell pointers.
//   clk  : system clock, rising edge
//   rstn : asynchronous active-low reset
//   fq   : slave side of multi_user_free_queue_if (push/pop handshake,
//          show-ahead head, empty, active and count status)
// After reset the queue writes pointer k into slot k for k = 0..DEPTH-1, then
// raises FQ_act and serves pushes/pops with zero-cycle show-ahead on the head.
module multi_user_free_queue
  import multi_user_free_queue_pkg::*;
#(
  parameter int DEPTH = FQ_DEPTH,
  parameter int PTR_W = FQ_PTR_W,
  parameter int CNT_W = FQ_CNT_W
) (
  input logic                      clk,
  input logic                      rstn,
  multi_user_free_queue_if.slave   fq
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  fq_state_e        state_q, state_d;
  logic [IDX_W-1:0] rd_idx_q, rd_idx_d;
  logic [IDX_W-1:0] wr_idx_q, wr_idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             empty_q, empty_d;
  logic             act_q, act_d;

  logic             do_pop, do_push;
  logic             ram_we;
  logic [PTR_W-1:0] ram_wdata, ram_rdata;

  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
    return (idx == LAST_IDX) ? '0 : idx + 1'b1;
  endfunction

  // FSM: state register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= ST_INIT;
    else       state_q <= state_d;
  end

  // FSM: next state. The tail index doubles as the init counter.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_INIT: if (wr_idx_q == LAST_IDX) state_d = ST_RUN;
      ST_RUN:  state_d = ST_RUN;
      default: state_d = ST_INIT;
    endcase
  end

  // FSM: outputs. A push into a full queue is accepted only when the head is
  // popped on the same edge, so the freed slot takes the new pointer.
  always_comb begin
    do_pop    = 1'b0;
    do_push   = 1'b0;
    ram_we    = 1'b0;
    ram_wdata = '0;
    unique case (state_q)
      ST_INIT: begin
        do_push   = 1'b1;
        ram_we    = 1'b1;
        ram_wdata = PTR_W'(wr_idx_q);
      end
      ST_RUN: begin
        do_pop    = fq.FQ_rd && (cnt_q != '0);
        do_push   = fq.FQ_wr && ((cnt_q != FULL_CNT) || do_pop);
        ram_we    = do_push;
        ram_wdata = fq.ptr_din[PTR_W-1:0];
      end
      default: ;
    endcase
  end

  // Index, count and status next-state
  always_comb begin
    rd_idx_d = do_pop  ? next_idx(rd_idx_q) : rd_idx_q;
    wr_idx_d = do_push ? next_idx(wr_idx_q) : wr_idx_q;
    cnt_d    = cnt_q;
    unique case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
    empty_d = (cnt_d == '0);
    act_d   = (state_d == ST_RUN);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_idx_q <= '0;
      wr_idx_q <= '0;
      cnt_q    <= '0;
      empty_q  <= 1'b1;
      act_q    <= 1'b0;
    end else begin
      rd_idx_q <= rd_idx_d;
      wr_idx_q <= wr_idx_d;
      cnt_q    <= cnt_d;
      empty_q  <= empty_d;
      act_q    <= act_d;
    end
  end

  fq_ptr_ram #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W),
    .IDX_W (IDX_W)
  ) u_fq_ptr_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (wr_idx_q),
    .wdata (ram_wdata),
    .raddr (rd_idx_q),
    .rdata (ram_rdata)
  );

  // Head is forced to zero until init completes; storage is not reset.
  assign fq.ptr_dout_s     = act_q ? ram_rdata : '0;
  assign fq.ptr_fifo_empty = empty_q;
  assign fq.FQ_act         = act_q;
  assign fq.FQ_count       = cnt_q;

endmodule

// File: tb/tb_multi_user_free_queue.sv
module tb_multi_user_free_queue;

  localparam int DEPTH = 512;

  logic clk  = 1'b0;
  logic rstn = 1'b0;

  always #5 clk = ~clk;

  multi_user_free_queue_if #(.PTR_W(10), .CNT_W(10)) fq ();

  multi_user_free_queue #(
    .DEPTH (DEPTH),
    .PTR_W (10),
    .CNT_W (10)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .fq   (fq.slave)
  );

  int checks = 0;
  int errors = 0;

  // Scoreboard: pointers the queue should hold, head first.
  logic [9:0] model[$];

  typedef struct {
    string       name;
    bit          rd;
    bit          wr;
    logic [15:0] din;
    int          exp_cnt;
    int          exp_head;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Called at a negedge: drives one request cycle, scores the sampled head
  // on a pop, then checks registered status after the edge.
  task automatic do_cycle(input bit rd, input bit wr, input logic [15:0] din);
    bit pop, push;
    fq.FQ_rd   = rd;
    fq.FQ_wr   = wr;
    fq.ptr_din = din;
    #1;
    pop  = rd && (model.size() > 0);
    push = wr && ((model.size() < DEPTH) || pop);
    if (pop) begin
      check("pop_sample", 32'(fq.ptr_dout_s), 32'(model[0]));
      void'(model.pop_front());
    end
    if (push) model.push_back(din[9:0]);
    @(negedge clk);
    fq.FQ_rd = 1'b0;
    fq.FQ_wr = 1'b0;
    check("count", 32'(fq.FQ_count), 32'(model.size()));
    check("empty", 32'(fq.ptr_fifo_empty), 32'(model.size() == 0));
    if (model.size() > 0) check("head", 32'(fq.ptr_dout_s), 32'(model[0]));
  endtask

  // Releases reset at a negedge and follows the 512-cycle self-initialisation.
  task automatic run_init();
    @(negedge clk);
    rstn = 1'b1;
    model.delete();
    for (int i = 0; i < DEPTH; i++) begin
      check("init_act", 32'(fq.FQ_act), 32'd0);
      check("init_count", 32'(fq.FQ_count), 32'(i));
      @(negedge clk);
    end
    check("act_after_init", 32'(fq.FQ_act), 32'd1);
    check("count_after_init", 32'(fq.FQ_count), 32'(DEPTH));
    check("empty_after_init", 32'(fq.ptr_fifo_empty), 32'd0);
    check("head_after_init", 32'(fq.ptr_dout_s), 32'd0);
    for (int i = 0; i < DEPTH; i++) model.push_back(10'(i));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{"pop0",        1'b1, 1'b0, 16'h0000, 511, 1};
    vecs[1] = '{"pop1",        1'b1, 1'b0, 16'h0000, 510, 2};
    vecs[2] = '{"pop2",        1'b1, 1'b0, 16'h0000, 509, 3};
    vecs[3] = '{"push0",       1'b0, 1'b1, 16'h0000, 510, 3};
    vecs[4] = '{"push1",       1'b0, 1'b1, 16'h0001, 511, 3};
    vecs[5] = '{"push2",       1'b0, 1'b1, 16'h0002, 512, 3};
    vecs[6] = '{"push_full",   1'b0, 1'b1, 16'hFC05, 512, 3};
    vecs[7] = '{"rdwr_full",   1'b1, 1'b1, 16'h0009, 512, 4};
    vecs[8] = '{"pop_free",    1'b1, 1'b0, 16'h0000, 511, 5};
    vecs[9] = '{"push_hibits", 1'b0, 1'b1, 16'hFC05, 512, 5};

    fq.FQ_rd   = 1'b0;
    fq.FQ_wr   = 1'b0;
    fq.ptr_din = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_act", 32'(fq.FQ_act), 32'd0);
    check("rst_count", 32'(fq.FQ_count), 32'd0);
    check("rst_empty", 32'(fq.ptr_fifo_empty), 32'd1);
    check("rst_head", 32'(fq.ptr_dout_s), 32'd0);

    run_init();

    // Table-driven vectors
    for (int i = 0; i < 10; i++) begin
      do_cycle(vecs[i].rd, vecs[i].wr, vecs[i].din);
      check({vecs[i].name, "_count"}, 32'(fq.FQ_count), 32'(vecs[i].exp_cnt));
      check({vecs[i].name, "_head"}, 32'(fq.ptr_dout_s), 32'(vecs[i].exp_head));
    end

    // 511 pops bring the masked 16'hFC05 return to the head
    for (int i = 0; i < 511; i++) do_cycle(1'b1, 1'b0, 16'h0000);
    check("hibits_head", 32'(fq.ptr_dout_s), 32'd5);
    check("hibits_count", 32'(fq.FQ_count), 32'd1);

    // Fill to 300, then simultaneous push/pop
    for (int i = 0; i < 299; i++) do_cycle(1'b0, 1'b1, 16'(100 + i));
    check("fill300_count", 32'(fq.FQ_count), 32'd300);
    do_cycle(1'b1, 1'b1, 16'd42);
    check("rdwr300_count", 32'(fq.FQ_count), 32'd300);
    check("rdwr300_head", 32'(fq.ptr_dout_s), 32'd100);

    // Drain, pop on empty, simultaneous push/pop on empty
    for (int i = 0; i < 300; i++) do_cycle(1'b1, 1'b0, 16'h0000);
    check("drain_empty", 32'(fq.ptr_fifo_empty), 32'd1);
    check("drain_count", 32'(fq.FQ_count), 32'd0);
    do_cycle(1'b1, 1'b0, 16'h0000);
    check("pop_empty_count", 32'(fq.FQ_count), 32'd0);
    check("pop_empty_flag", 32'(fq.ptr_fifo_empty), 32'd1);
    do_cycle(1'b1, 1'b1, 16'd7);
    check("rdwr_empty_count", 32'(fq.FQ_count), 32'd1);
    check("rdwr_empty_head", 32'(fq.ptr_dout_s), 32'd7);
    check("rdwr_empty_flag", 32'(fq.ptr_fifo_empty), 32'd0);

    // Mid-operation reset after 100 pops
    rstn = 1'b0;
    #2;
    run_init();
    for (int i = 0; i < 100; i++) do_cycle(1'b1, 1'b0, 16'h0000);
    check("pre_rst_head", 32'(fq.ptr_dout_s), 32'd100);
    #2;
    rstn = 1'b0;
    #1;
    check("midrst_act", 32'(fq.FQ_act), 32'd0);
    check("midrst_count", 32'(fq.FQ_count), 32'd0);
    check("midrst_empty", 32'(fq.ptr_fifo_empty), 32'd1);
    run_init();
    do_cycle(1'b1, 1'b0, 16'h0000);
    check("reinit_pop_head", 32'(fq.ptr_dout_s), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
